// File: rtl/interleaver_ctrl.sv
// Sequencing controller for the 11-level FIFO shift RAM of a convolutional byte interleaver.
// Rotates a 12-position commutator; branch 0 bypasses the RAM, branches 1..11 use levels 0..10.
module interleaver_ctrl #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sync,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sync,
    output logic        ram_re,
    output logic [3:0]  sel,
    output logic [10:0] push,
    output logic [7:0]  din,
    input  logic [7:0]  ram_dout,
    output logic [3:0]  branch,
    output logic        sync_err
);

    if (RD_LAT != 1) begin : g_lat_check
        $error("interleaver_ctrl supports only RD_LAT == 1");
    end

    typedef enum logic [1:0] {StIdle, StRd, StWr, StOut} state_e;

    state_e      state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic        out_sync_q;
    logic        ram_re_q;
    logic [3:0]  sel_q;
    logic [10:0] push_q;
    logic [7:0]  din_q;
    logic [7:0]  hold_q;
    logic [3:0]  branch_q;
    logic        sync_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sync_q  <= 1'b0;
            ram_re_q    <= 1'b0;
            sel_q       <= 4'd0;
            push_q      <= 11'd0;
            din_q       <= 8'h00;
            hold_q      <= 8'h00;
            branch_q    <= 4'd0;
            sync_err_q  <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        hold_q     <= in_data;
                        // A sync byte always takes the bypass; off branch 0 it realigns.
                        if (branch_q == 4'd0 || in_sync) begin
                            out_data_q  <= in_data;
                            out_sync_q  <= in_sync;
                            out_valid_q <= 1'b1;
                            state_q     <= StOut;
                            if (in_sync && branch_q != 4'd0) begin
                                sync_err_q <= 1'b1;
                                branch_q   <= 4'd0;
                            end
                        end else begin
                            ram_re_q <= 1'b1;
                            sel_q    <= branch_q - 4'd1;
                            state_q  <= StRd;
                        end
                    end
                end
                StRd: begin
                    ram_re_q <= 1'b0;
                    push_q   <= 11'd1 << sel_q;
                    din_q    <= hold_q;
                    state_q  <= StWr;
                end
                StWr: begin
                    push_q      <= 11'd0;
                    out_data_q  <= ram_dout;
                    out_sync_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        branch_q    <= (branch_q == 4'd11) ? 4'd0 : branch_q + 4'd1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sync  = out_sync_q;
    assign ram_re    = ram_re_q;
    assign sel       = sel_q;
    assign push      = push_q;
    assign din       = din_q;
    assign branch    = branch_q;
    assign sync_err  = sync_err_q;

endmodule
